// File: rtl/ddr_dq_rcvr_lpbk_chk.sv
// DQ loopback receive checker: seeds a local pattern generator from the returned
// bit stream, acquires lock, then counts mismatches with loss-of-lock detection.
module ddr_dq_rcvr_lpbk_chk #(
  parameter int unsigned ERR_WIDTH  = 16,
  parameter int unsigned LOCK_LEN   = 32,
  parameter int unsigned LOL_WIN    = 64,
  parameter int unsigned LOL_THRESH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [1:0]           i_mode,
  input  logic                 i_static_val,
  input  logic                 i_d_valid,
  input  logic                 i_d_lpbk,
  input  logic                 i_clr_err,
  output logic                 o_lock,
  output logic                 o_err,
  output logic [ERR_WIDTH-1:0] o_err_cnt,
  output logic                 o_err_sat,
  output logic [1:0]           o_state
);

  localparam int unsigned MW = $clog2(LOCK_LEN + 1);
  localparam int unsigned WW = $clog2(LOL_WIN + 1);
  localparam int unsigned EW = $clog2(LOL_THRESH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_ACQ    = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [14:0]           lfsr_q, lfsr_d;
  logic [3:0]            seed_cnt_q, seed_cnt_d;
  logic [MW-1:0]         match_q, match_d;
  logic [WW-1:0]         win_cnt_q, win_cnt_d;
  logic [EW-1:0]         win_err_q, win_err_d;
  logic [1:0]            mode_q, mode_d;
  logic                  lock_q, lock_d;
  logic                  err_q, err_d;
  logic                  sat_q, sat_d;
  logic [ERR_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  exp_bit;
  logic                  mism;
  logic [3:0]            seed_len;
  logic [EW-1:0]         werr;

  // Mode 2 expects the inverse of the last generated bit, which is lfsr[0]
  // because ACQ/LOCKED shift the expected bit in.
  always_comb begin
    exp_bit  = 1'b0;
    seed_len = 4'd1;
    case (mode_q)
      2'd0: begin exp_bit = lfsr_q[6] ^ lfsr_q[5];   seed_len = 4'd7;  end
      2'd1: begin exp_bit = lfsr_q[14] ^ lfsr_q[13]; seed_len = 4'd15; end
      2'd2: exp_bit = ~lfsr_q[0];
      default: exp_bit = i_static_val;
    endcase
    mism = i_d_lpbk ^ exp_bit;
    werr = win_err_q + EW'(mism);
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_cnt_d = seed_cnt_q;
    match_d    = match_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    mode_d     = mode_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    if (!i_en) begin
      state_d    = ST_IDLE;
      mode_d     = i_mode;
      seed_cnt_d = '0;
      match_d    = '0;
      win_cnt_d  = '0;
      win_err_d  = '0;
    end else if (state_q == ST_IDLE || i_mode != mode_q) begin
      state_d    = ST_SEED;
      mode_d     = i_mode;
      seed_cnt_d = '0;
      match_d    = '0;
      win_cnt_d  = '0;
      win_err_d  = '0;
    end else if (i_d_valid) begin
      case (state_q)
        ST_SEED: begin
          lfsr_d = {lfsr_q[13:0], i_d_lpbk};
          if (seed_cnt_q + 4'd1 == seed_len) begin
            state_d    = ST_ACQ;
            seed_cnt_d = '0;
            match_d    = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 4'd1;
          end
        end
        ST_ACQ: begin
          lfsr_d = {lfsr_q[13:0], exp_bit};
          if (mism) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            match_d    = '0;
          end else if (match_q + MW'(1) == MW'(LOCK_LEN)) begin
            state_d   = ST_LOCKED;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end
        ST_LOCKED: begin
          lfsr_d = {lfsr_q[13:0], exp_bit};
          if (mism) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + ERR_WIDTH'(1);
          end
          win_cnt_d = (win_cnt_q == WW'(LOL_WIN - 1)) ? '0 : win_cnt_q + WW'(1);
          if (werr >= EW'(LOL_THRESH)) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WW'(LOL_WIN - 1)) begin
            win_err_d = '0;
          end else begin
            win_err_d = werr;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    sat_d  = sat_q | (cnt_d == '1);
    lock_d = (state_d == ST_LOCKED);
    // Clear takes priority over a same-cycle increment.
    if (i_clr_err) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= '0;
      seed_cnt_q <= '0;
      match_q    <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      mode_q     <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_cnt_q <= seed_cnt_d;
      match_q    <= match_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      mode_q     <= mode_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_lock    = lock_q;
  assign o_err     = err_q;
  assign o_err_cnt = cnt_q;
  assign o_err_sat = sat_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_ddr_dq_rcvr_lpbk_chk.sv
// Directed bench for the DQ loopback checker: PRBS7/PRBS15/toggle/static streams,
// error injection, loss-of-lock, saturation (4-bit instance), reset and enable.
module tb_ddr_dq_rcvr_lpbk_chk;

  logic        clk = 1'b0;
  logic        rst, en, static_val, valid, dlpbk, clr;
  logic [1:0]  mode;

  logic        lock, err, sat;
  logic [15:0] cnt;
  logic [1:0]  state;
  logic        lock4, err4, sat4;
  logic [3:0]  cnt4;
  logic [1:0]  state4;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned err_seen = 0;
  logic [6:0]  p7;
  logic [14:0] p15;
  logic        b;

  always #5 clk = ~clk;

  ddr_dq_rcvr_lpbk_chk u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_static_val(static_val),
    .i_d_valid(valid), .i_d_lpbk(dlpbk), .i_clr_err(clr),
    .o_lock(lock), .o_err(err), .o_err_cnt(cnt), .o_err_sat(sat), .o_state(state)
  );

  ddr_dq_rcvr_lpbk_chk #(.ERR_WIDTH(4), .LOL_THRESH(64)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_static_val(static_val),
    .i_d_valid(valid), .i_d_lpbk(dlpbk), .i_clr_err(clr),
    .o_lock(lock4), .o_err(err4), .o_err_cnt(cnt4), .o_err_sat(sat4), .o_state(state4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input logic v, input logic d);
    valid = v;
    dlpbk = d;
    @(posedge clk);
    #1;
    if (err === 1'b1) err_seen++;
  endtask

  function automatic logic gen7();
    logic nb;
    nb = p7[6] ^ p7[5];
    p7 = {p7[5:0], nb};
    return nb;
  endfunction

  function automatic logic gen15();
    logic nb;
    nb = p15[14] ^ p15[13];
    p15 = {p15[13:0], nb};
    return nb;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; static_val = 1'b0;
    valid = 1'b0; dlpbk = 1'b0; clr = 1'b0;
    p7 = 7'h5A; p15 = 15'h1234;
    step(0, 0);
    step(0, 0);
    check("rst_state", state, 0);
    check("rst_lock", lock, 0);
    check("rst_err", err, 0);
    check("rst_cnt", cnt, 0);
    check("rst_sat", sat, 0);

    // PRBS7 clean acquisition
    rst = 1'b0; en = 1'b1;
    step(1, 0);
    check("p7_seed_entry", state, 1);
    for (int i = 0; i < 7; i++) begin
      step(1, gen7());
      if (i == 5) check("p7_seed6", state, 1);
      if (i == 6) check("p7_acq", state, 2);
    end
    for (int i = 0; i < 32; i++) begin
      step(1, gen7());
      if (i == 30) begin check("p7_acq31", state, 2); check("p7_nolock31", lock, 0); end
      if (i == 31) begin check("p7_locked", state, 3); check("p7_lock", lock, 1); end
    end
    err_seen = 0;
    for (int i = 0; i < 20; i++) step(1, gen7());
    check("p7_clean_cnt", cnt, 0);
    check("p7_clean_pulses", err_seen, 0);
    check("p7_clean_lock", lock, 1);

    // PRBS7 loss of lock after 4 errors, then relock
    err_seen = 0;
    for (int i = 0; i < 20; i++) begin
      b = gen7();
      step(1, b ^ (i == 2 || i == 5 || i == 9 || i == 12));
      if (i == 2)  begin check("lol_err_pulse", err, 1); check("lol_cnt1", cnt, 1); end
      if (i == 3)  check("lol_err_low", err, 0);
      if (i == 9)  begin check("lol_cnt3", cnt, 3); check("lol_lock3", lock, 1); end
      if (i == 12) begin
        check("lol_state", state, 1); check("lol_lock", lock, 0); check("lol_cnt4", cnt, 4);
      end
    end
    check("relock_acq", state, 2);
    for (int i = 0; i < 32; i++) begin
      step(1, gen7());
      if (i == 30) check("relock_acq31", state, 2);
    end
    check("relock_state", state, 3);
    check("relock_lock", lock, 1);
    check("relock_cnt_held", cnt, 4);
    check("lol_pulses", err_seen, 4);

    clr = 1'b1;
    step(1, gen7());
    clr = 1'b0;
    check("clr_cnt", cnt, 0);

    // PRBS15: mode change forces reseed, single bit error
    mode = 2'd1;
    step(0, 0);
    check("mode_chg_state", state, 1);
    check("mode_chg_lock", lock, 0);
    for (int i = 0; i < 15; i++) begin
      step(1, gen15());
      if (i == 13) check("p15_seed14", state, 1);
    end
    check("p15_acq", state, 2);
    for (int i = 0; i < 32; i++) step(1, gen15());
    check("p15_lock", lock, 1);
    err_seen = 0;
    b = gen15();
    step(1, ~b);
    check("p15_err_pulse", err, 1);
    check("p15_cnt1", cnt, 1);
    check("p15_lock_kept", lock, 1);
    for (int i = 0; i < 3; i++) step(1, gen15());
    check("p15_one_pulse", err_seen, 1);
    check("p15_err_low", err, 0);
    for (int i = 0; i < 10; i++) begin
      b = gen15();
      step(1, b ^ (i == 3 || i == 6));
    end
    check("p15_cnt3", cnt, 3);
    check("p15_state3", state, 3);

    // Reset mid-operation overrides everything
    rst = 1'b1;
    b = gen15();
    step(1, ~b);
    check("mid_rst_state", state, 0);
    check("mid_rst_lock", lock, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_sat", sat, 0);
    rst = 1'b0;
    step(1, 0);
    check("post_rst_seed", state, 1);
    en = 1'b0;
    step(1, 0);
    check("en_low_idle", state, 0);

    // Toggle pattern with 50% valid duty
    mode = 2'd2; en = 1'b1;
    step(1, 0);
    check("tog_seed", state, 1);
    step(0, 1);
    check("tog_seed_hold", state, 1);
    step(1, 1);
    check("tog_acq", state, 2);
    for (int k = 0; k < 32; k++) begin
      b = k[0];
      step(1, b);
      if (k == 30) check("tog_acq31", state, 2);
      step(0, b);
      if (k == 30) check("tog_acq31_inv", state, 2);
    end
    check("tog_locked", state, 3);
    check("tog_cnt", cnt, 0);

    // Saturation on the 4-bit counter instance
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0; mode = 2'd3; static_val = 1'b0;
    step(1, 0);
    step(1, 0);
    check("st_acq", state4, 2);
    for (int i = 0; i < 32; i++) step(1, 0);
    check("st_locked", state4, 3);
    for (int i = 0; i < 17; i++) begin
      step(1, 1);
      if (i == 13) begin check("sat_cnt14", cnt4, 14); check("sat_flag14", sat4, 0); end
      if (i == 14) begin check("sat_cnt15", cnt4, 15); check("sat_flag15", sat4, 1); end
    end
    check("sat_hold_cnt", cnt4, 15);
    check("sat_hold_flag", sat4, 1);
    check("sat_lock", lock4, 1);
    clr = 1'b1;
    step(1, 1);
    check("sat_clr_cnt", cnt4, 0);
    check("sat_clr_flag", sat4, 0);
    check("sat_clr_pulse", err4, 1);
    clr = 1'b0;
    step(1, 1);
    check("sat_after_clr", cnt4, 1);
    clr = 1'b1;
    step(1, 1);
    check("clr_beats_inc", cnt4, 0);
    clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
